timer_dbus_slave: RTL and testbench

Memory-mapped machine timer that responds to the core's data-bus accesses (address, byte mask, write enable, active-low chip select), on the same port shape the core already drives into data memory. It holds a 64-bit free-running time counter with a programmable prescaler, a 64-bit compare register, a sticky match flag and a level interrupt output. The block sits beside data memory and is selected by an external address decoder through `cs`.

---
 rtl/timer_dbus_slave.sv | 127 ++++++++++++
 tb/tb_timer_dbus_slave.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dbus_slave.sv
// Memory-mapped machine timer on the core's data-bus port shape: 64-bit
// prescaled time counter, 64-bit compare, sticky match flag and level IRQ.
module timer_dbus_slave #(
    parameter int DW         = 32,
    parameter int PRESCALE_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    mask,
    input  logic [DW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          timer_irq_o
);

    localparam logic [2:0] A_MTIME_LO = 3'd0;
    localparam logic [2:0] A_MTIME_HI = 3'd1;
    localparam logic [2:0] A_CMP_LO   = 3'd2;
    localparam logic [2:0] A_CMP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL     = 3'd4;
    localparam logic [2:0] A_STATUS   = 3'd5;

    logic [63:0]           mtime, mtime_nxt;
    logic [63:0]           mtimecmp, mtimecmp_nxt;
    logic                  en, ie, match;
    logic [PRESCALE_W-1:0] prescale, pre_cnt;
    logic [DW-1:0]         ctrl_word, ctrl_new;
    logic [2:0]            sel;
    logic                  wr, tick, cmp_hit, match_clr;
    logic                  unused_bits;

    // Merge the enabled bytes of a write into an existing word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    assign sel       = addr_i[4:2];
    // A write with no byte enables is a no-op, including for collision rules.
    assign wr        = !cs && we && (mask != 4'b0000);
    assign tick      = en && (pre_cnt == prescale);
    assign cmp_hit   = en && (mtime >= mtimecmp);
    assign match_clr = wr && (sel == A_STATUS) && mask[0] && wdata_i[0];
    assign ctrl_new  = byte_merge(ctrl_word, wdata_i, mask);
    assign timer_irq_o = match & ie;
    assign unused_bits = ^{addr_i[DW-1:5], addr_i[1:0], ctrl_new[7:2],
                           ctrl_new[DW-1:8+PRESCALE_W]};

    // CTRL as seen on the bus; undefined bits read as zero.
    always_comb begin
        ctrl_word = '0;
        ctrl_word[0] = en;
        ctrl_word[1] = ie;
        ctrl_word[8 +: PRESCALE_W] = prescale;
    end

    // Next time value: a bus write to either word wins and drops the whole
    // increment (no carry into the unwritten word).
    always_comb begin
        mtime_nxt = mtime;
        if (wr && sel == A_MTIME_LO)
            mtime_nxt[31:0] = byte_merge(mtime[31:0], wdata_i, mask);
        else if (wr && sel == A_MTIME_HI)
            mtime_nxt[63:32] = byte_merge(mtime[63:32], wdata_i, mask);
        else if (tick)
            mtime_nxt = mtime + 64'd1;
    end

    // Next compare value from byte-masked writes.
    always_comb begin
        mtimecmp_nxt = mtimecmp;
        if (wr && sel == A_CMP_LO)
            mtimecmp_nxt[31:0] = byte_merge(mtimecmp[31:0], wdata_i, mask);
        else if (wr && sel == A_CMP_HI)
            mtimecmp_nxt[63:32] = byte_merge(mtimecmp[63:32], wdata_i, mask);
    end

    // Register state; reset overrides writes and increments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b0;
            ie       <= 1'b0;
            prescale <= '0;
            pre_cnt  <= '0;
            match    <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= mtimecmp_nxt;
            if (wr && sel == A_CTRL) begin
                en       <= ctrl_new[0];
                ie       <= ctrl_new[1];
                prescale <= ctrl_new[8 +: PRESCALE_W];
                pre_cnt  <= '0;
            end else if (en) begin
                pre_cnt  <= tick ? '0 : pre_cnt + 1'b1;
            end
            // A clear loses against a compare condition that still holds.
            match <= cmp_hit | (match & ~match_clr);
        end
    end

    // Combinational read mux, no side effects; idle bus reads zero.
    always_comb begin
        rdata_o = '0;
        if (!cs) begin
            case (sel)
                A_MTIME_LO: rdata_o = mtime[31:0];
                A_MTIME_HI: rdata_o = mtime[63:32];
                A_CMP_LO:   rdata_o = mtimecmp[31:0];
                A_CMP_HI:   rdata_o = mtimecmp[63:32];
                A_CTRL:     rdata_o = ctrl_word;
                A_STATUS:   rdata_o = {{(DW-1){1'b0}}, match};
                default:    rdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_dbus_slave.sv
// Directed self-checking bench for timer_dbus_slave.
module tb_timer_dbus_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        cs = 1'b1;
    logic        we = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic        timer_irq_o;

    int tests = 0;
    int fails = 0;

    timer_dbus_slave #(.DW(32), .PRESCALE_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs(cs), .we(we), .mask(mask),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
        .timer_irq_o(timer_irq_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] m);
        cs = 1'b0; we = 1'b1; addr_i = {27'b0, off, 2'b00}; wdata_i = d; mask = m;
        @(posedge clk_i);
        #1;
        cs = 1'b1; we = 1'b0; mask = 4'h0;
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] v);
        cs = 1'b0; we = 1'b0; addr_i = {27'b0, off, 2'b00}; mask = 4'h0;
        #1;
        v = rdata_o;
        cs = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] exp_v [8];
        exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd(i[2:0], v);
            tests++;
            if (v !== exp_v[i]) begin
                fails++;
                $display("FAIL reset_off%0d got %h want %h", i, v, exp_v[i]);
            end
        end
        tests++;
        if (timer_irq_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_irq got %b want 0", timer_irq_o);
        end
        cs = 1'b0; addr_i = 32'h8; #1;
        cs = 1'b1; #1;
        tests++;
        if (rdata_o !== 32'h0) begin
            fails++;
            $display("FAIL idle_rdata got %h want 0", rdata_o);
        end
    endtask

    task automatic test_prescale;
        logic [31:0] v, base;
        wr(3'd4, 32'h001, 4'hF);
        cyc(10);
        rd(3'd0, v);
        tests++;
        if (v !== 32'd10) begin
            fails++;
            $display("FAIL presc0_lo got %0d want 10", v);
        end
        wr(3'd4, 32'h301, 4'hF);
        rd(3'd0, base);
        rd(3'd4, v);
        tests++;
        if (v !== 32'h301) begin
            fails++;
            $display("FAIL ctrl_read got %h want 301", v);
        end
        cyc(12);
        rd(3'd0, v);
        tests++;
        if (v - base !== 32'd3) begin
            fails++;
            $display("FAIL presc3_delta got %0d want 3", v - base);
        end
    endtask

    task automatic test_compare_irq;
        logic [31:0] v;
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd0, 32'h0, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd3, 32'h0, 4'hF);
        wr(3'd2, 32'd5, 4'hF);
        wr(3'd4, 32'h003, 4'hF);
        cyc(5);
        rd(3'd0, v);
        tests++;
        if (v !== 32'd5 || timer_irq_o !== 1'b0) begin
            fails++;
            $display("FAIL cmp_pre lo=%0d irq=%b want lo=5 irq=0", v, timer_irq_o);
        end
        cyc(1);
        rd(3'd5, v);
        tests++;
        if (timer_irq_o !== 1'b1 || v !== 32'h1) begin
            fails++;
            $display("FAIL cmp_rise irq=%b status=%h want irq=1 status=1", timer_irq_o, v);
        end
        wr(3'd5, 32'h1, 4'h1);
        rd(3'd5, v);
        tests++;
        if (v !== 32'h1) begin
            fails++;
            $display("FAIL clr_held got %h want 1", v);
        end
        wr(3'd2, 32'hFFFF, 4'hF);
        wr(3'd5, 32'h1, 4'h1);
        rd(3'd5, v);
        tests++;
        if (v !== 32'h0 || timer_irq_o !== 1'b0) begin
            fails++;
            $display("FAIL clr_ok status=%h irq=%b want 0 0", v, timer_irq_o);
        end
        wr(3'd4, 32'h001, 4'hF);
        wr(3'd2, 32'h0, 4'hF);
        cyc(1);
        rd(3'd5, v);
        tests++;
        if (v !== 32'h1 || timer_irq_o !== 1'b0) begin
            fails++;
            $display("FAIL ie_gate status=%h irq=%b want 1 0", v, timer_irq_o);
        end
    endtask

    task automatic test_carry_wrap;
        logic [31:0] lo, hi;
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wr(3'd1, 32'h0, 4'hF);
        wr(3'd4, 32'h001, 4'hF);
        cyc(2);
        rd(3'd1, hi);
        rd(3'd0, lo);
        tests++;
        if (hi !== 32'h1 || lo !== 32'h0) begin
            fails++;
            $display("FAIL carry got %h_%h want 00000001_00000000", hi, lo);
        end
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd0, 32'hFFFF_FFFF, 4'hF);
        wr(3'd1, 32'hFFFF_FFFF, 4'hF);
        wr(3'd4, 32'h001, 4'hF);
        cyc(1);
        rd(3'd1, hi);
        rd(3'd0, lo);
        tests++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            fails++;
            $display("FAIL wrap got %h_%h want 0_0", hi, lo);
        end
    endtask

    task automatic test_byte_mask;
        logic [31:0] v;
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd2, 32'h1122_3344, 4'hF);
        wr(3'd2, 32'hAABB_CCDD, 4'b0101);
        rd(3'd2, v);
        tests++;
        if (v !== 32'h11BB_33DD) begin
            fails++;
            $display("FAIL bytemask got %h want 11bb33dd", v);
        end
        wr(3'd2, 32'hFFFF_FFFF, 4'h0);
        rd(3'd2, v);
        tests++;
        if (v !== 32'h11BB_33DD) begin
            fails++;
            $display("FAIL mask0 got %h want 11bb33dd", v);
        end
        wr(3'd6, 32'h1234_5678, 4'hF);
        rd(3'd6, v);
        tests++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL unmapped got %h want 0", v);
        end
    endtask

    task automatic test_collision;
        logic [31:0] lo, hi;
        wr(3'd4, 32'h0, 4'hF);
        wr(3'd0, 32'hFFFF_FFFE, 4'hF);
        wr(3'd1, 32'h7, 4'hF);
        wr(3'd4, 32'h001, 4'hF);
        cyc(1);
        wr(3'd0, 32'h100, 4'hF);
        rd(3'd0, lo);
        rd(3'd1, hi);
        tests++;
        if (lo !== 32'h100 || hi !== 32'h7) begin
            fails++;
            $display("FAIL coll_lo got %h_%h want 00000007_00000100", hi, lo);
        end
        cyc(1);
        rd(3'd0, lo);
        tests++;
        if (lo !== 32'h101) begin
            fails++;
            $display("FAIL coll_next got %h want 101", lo);
        end
        wr(3'd1, 32'h22, 4'hF);
        rd(3'd0, lo);
        rd(3'd1, hi);
        tests++;
        if (lo !== 32'h101 || hi !== 32'h22) begin
            fails++;
            $display("FAIL coll_hi got %h_%h want 00000022_00000101", hi, lo);
        end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] v, c;
        wr(3'd4, 32'h003, 4'hF);
        cyc(3);
        rst_i = 1'b1;
        cyc(1);
        rst_i = 1'b0;
        rd(3'd0, v);
        rd(3'd4, c);
        tests++;
        if (v !== 32'h0 || c !== 32'h0 || timer_irq_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset lo=%h ctrl=%h irq=%b want 0 0 0", v, c, timer_irq_o);
        end
        rd(3'd3, v);
        tests++;
        if (v !== 32'hFFFF_FFFF) begin
            fails++;
            $display("FAIL midreset_cmp got %h want ffffffff", v);
        end
        wr(3'd4, 32'h301, 4'hF);
        cyc(3);
        rd(3'd0, v);
        tests++;
        if (v !== 32'h0) begin
            fails++;
            $display("FAIL first_tick_early got %0d want 0", v);
        end
        cyc(1);
        rd(3'd0, v);
        tests++;
        if (v !== 32'h1) begin
            fails++;
            $display("FAIL first_tick got %0d want 1", v);
        end
    endtask

    initial begin
        test_reset;
        test_prescale;
        test_compare_irq;
        test_carry_wrap;
        test_byte_mask;
        test_collision;
        test_reset_midcount;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
